// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit with valid/ready handshake.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational multiplier.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_r;
    logic              neg;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   rem;
    logic [2*XLEN-1:0] prod;
    logic              a_sgn, b_sgn, sa, sb, neg_in, dz, ovf, quick;
    logic [XLEN-1:0]   ma, mb, spec_res, quick_res, rem_n, quo_n, rq, fin;
    logic [XLEN:0]     add, trial, diff;
    logic [2*XLEN-1:0] prod_mul, prod_n, pm;
    // Decode signedness, magnitudes, sign flag and the non-iterating special cases at accept
    always_comb begin
        a_sgn    = op[2] ? !op[0] : (op[1] ^ op[0]);
        b_sgn    = op[2] ? !op[0] : (op[1:0] == 2'b01);
        sa       = a_sgn & a[XLEN-1];
        sb       = b_sgn & b[XLEN-1];
        ma       = sa ? -a : a;
        mb       = sb ? -b : b;
        neg_in   = (op[2] & op[1]) ? sa : (sa ^ sb);
        dz       = op[2] & (b == '0);
        ovf      = op[2] & !op[0] & (a == SMIN) & (b == '1);
        spec_res = dz ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    end
`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN+1:0] fp;
    // Single-cycle signed (XLEN+1)x(XLEN+1) product covers all multiply signedness variants
    always_comb begin
        fa        = {a_sgn & a[XLEN-1], a};
        fb        = {b_sgn & b[XLEN-1], b};
        fp        = fa * fb;
        quick     = dz | ovf | !op[2];
        quick_res = op[2] ? spec_res : (op[1:0] == 2'b00 ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN]);
    end
`else
    // Only divide special cases bypass iteration
    always_comb begin
        quick     = dz | ovf;
        quick_res = spec_res;
    end
`endif
    // One shift-add multiply step or one restoring divide step, plus the sign-corrected final value
    always_comb begin
        add      = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, prod[0] ? mcand : '0};
        prod_mul = {add, prod[XLEN-1:1]};
        trial    = {rem, prod[XLEN-1]};
        diff     = trial - {1'b0, mcand};
        rem_n    = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
        quo_n    = {prod[XLEN-2:0], ~diff[XLEN]};
        prod_n   = op_r[2] ? {prod[2*XLEN-1:XLEN], quo_n} : prod_mul;
        pm       = neg ? -prod_mul : prod_mul;
        rq       = op_r[1] ? rem_n : quo_n;
        fin      = op_r[2] ? (neg ? -rq : rq) : (op_r[1:0] == 2'b00 ? pm[XLEN-1:0] : pm[2*XLEN-1:XLEN]);
    end
    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            cnt       <= '0;
            op_r      <= '0;
            neg       <= 1'b0;
            mcand     <= '0;
            rem       <= '0;
            prod      <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_r     <= op;
                    neg      <= neg_in;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    if (quick) begin
                        result    <= quick_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= CALC;
                        cnt   <= CNT_INIT;
                        mcand <= op[2] ? mb : ma;
                        prod  <= {{XLEN{1'b0}}, op[2] ? ma : mb};
                        rem   <= '0;
                    end
                end
                CALC: begin
                    cnt  <= cnt - 1'b1;
                    prod <= prod_n;
                    rem  <= rem_n;
                    if (cnt == CNT_W'(1)) begin
                        result    <= fin;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (XLEN=32), honours MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;
    localparam int XLEN = 32;
    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [2:0] op;
    logic [31:0] a, b, result;
    logic [31:0] sb_q[$];
    logic [31:0] last_exp;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy;
        logic [63:0] p;
        logic [31:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        case (f)
            3'd0: begin p = ux * uy; r = p[31:0]; end
            3'd1: begin p = sx * sy; r = p[63:32]; end
            3'd2: begin p = sx * uy; r = p[63:32]; end
            3'd3: begin p = ux * uy; r = p[63:32]; end
            3'd4: begin
                p = sx / ((y == 0) ? 64'sd1 : sy);
                r = (y == 0) ? 32'hFFFFFFFF : (x == 32'h80000000 && y == 32'hFFFFFFFF) ? x : p[31:0];
            end
            3'd5: r = (y == 0) ? 32'hFFFFFFFF : x / y;
            3'd6: begin
                p = sx % ((y == 0) ? 64'sd1 : sy);
                r = (y == 0) ? x : (x == 32'h80000000 && y == 32'hFFFFFFFF) ? 32'h0 : p[31:0];
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int hold);
        int lat, exp_lat;
        logic [31:0] want;
        exp_lat = latency(f, x, y);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL accept_ready op=%0d got=%b want=1", f, in_ready); end
        op = f; a = x; b = y; in_valid = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        total++;
        if (lat !== exp_lat) begin bad++; $display("FAIL latency op=%0d a=%h b=%h got=%0d want=%0d", f, x, y, lat, exp_lat); end
        want = sb_q.pop_front();
        total++;
        if (result !== want) begin bad++; $display("FAIL result op=%0d a=%h b=%h got=%h want=%h", f, x, y, result, want); end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total++;
            if (result !== want || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL hold cyc=%0d got res=%h ov=%b ir=%b busy=%b want res=%h ov=1 ir=0 busy=1", i, result, out_valid, in_ready, busy, want);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL release got ov=%b ir=%b busy=%b want ov=0 ir=1 busy=0", out_valid, in_ready, busy);
        end
        last_exp = want;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
            bad++;
            $display("FAIL reset got ir=%b ov=%b busy=%b res=%h want 1 0 0 0", in_ready, out_valid, busy, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul;
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    endtask

    task automatic test_div;
        run_op(3'd4, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, 0);
        run_op(3'd6, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, 0);
        run_op(3'd5, 32'd20, 32'd6, 32'd3, 0);
        run_op(3'd7, 32'hFFFFFFFF, 32'd10, 32'd5, 0);
    endtask

    task automatic test_special;
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 0);
        run_op(3'd7, 32'd5, 32'd0, 32'd5, 0);
        run_op(3'd4, 32'd9, 32'd0, 32'hFFFFFFFF, 0);
        run_op(3'd6, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 0);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);
    endtask

    task automatic test_backpressure;
        run_op(3'd5, 32'd20, 32'd6, 32'd3, 5);
        run_op(3'd7, 32'd5, 32'd0, 32'd5, 5);
    endtask

    task automatic test_flush;
        int seen;
        @(negedge clk);
        op = 3'd4; a = 32'hFFFFFFEC; b = 32'd6; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== last_exp) begin
            bad++;
            $display("FAIL flush_idle got ov=%b ir=%b busy=%b res=%h want 0 1 0 %h", out_valid, in_ready, busy, result, last_exp);
        end
        op = 3'd5; a = 32'd1; b = 32'd0; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_block got ir=%b busy=%b want ir=1 busy=0", in_ready, busy);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid === 1'b1) seen++; end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL flush_no_output got=%0d valid cycles want=0", seen); end
        run_op(3'd4, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, 0);
    endtask

    task automatic test_rst_mid;
        @(negedge clk);
        op = 3'd0; a = 32'd123; b = 32'd456; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid got ir=%b ov=%b busy=%b res=%h want 1 0 0 0", in_ready, out_valid, busy, result);
        end
        run_op(3'd6, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, 0);
    endtask

    task automatic test_random;
        logic [31:0] x, y;
        logic [2:0] f;
        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: x = 32'($urandom_range(0, 50));
                1: x = 32'h80000000 + 32'($urandom_range(0, 3));
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: y = 32'($urandom_range(0, 9));
                1: y = 32'hFFFFFFFF - 32'($urandom_range(0, 2));
                default: y = $urandom;
            endcase
            run_op(f, x, y, model(f, x, y), 0);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; last_exp = '0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
